// File: rtl/cache_pkg.sv
// Shared constants and state encoding for the cache line-refill engine.
// Optional feature macro: CACHE_REFILL_CRIT_FIRST_EN (critical-byte-first fetch order).
package cache_pkg;

    localparam int unsigned BLOCK_BYTES = 32;
    localparam int unsigned TAG_W       = 24;
    localparam int unsigned NUM_LINES   = 8;

    // Address field layout: [tag | line index | byte offset]
    localparam int unsigned OFF_W   = $clog2(BLOCK_BYTES);
    localparam int unsigned IDX_W   = $clog2(NUM_LINES);
    localparam int unsigned OFF_LSB = 0;
    localparam int unsigned IDX_LSB = OFF_LSB + OFF_W;
    localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;

    // Encodings kept identical to the legacy localparam values
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DONE   = 3'd4
    } refill_state_t;

endpackage

// File: rtl/cache_refill_ctrl_onehot_dec.sv
// Binary index to one-hot decoder with enable; all-zero output when disabled.
// Used for the byte-select and line-select fill ports of the refill engine.
module onehot_dec #(
    parameter int unsigned N = 5
) (
    input  logic                 en,
    input  logic [N-1:0]         idx,
    output logic [(1 << N)-1:0]  onehot
);

    // Single bit set at position idx while enabled
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Line-refill engine: fetches a 32-byte block one byte per accepted memory beat,
// writes each byte into the selected line, then commits tag and valid bit.
// Optional feature macro: CACHE_REFILL_CRIT_FIRST_EN -- fetch starts at the
// missing byte offset and a crit_valid pulse marks the requested byte.
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned BLOCK_BYTES = cache_pkg::BLOCK_BYTES,
    parameter int unsigned TAG_W       = cache_pkg::TAG_W,
    parameter int unsigned NUM_LINES   = cache_pkg::NUM_LINES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   miss_req,
    input  logic [31:0]            miss_addr,
    output logic                   mem_rd_req,
    output logic [31:0]            mem_addr,
    input  logic                   mem_rd_valid,
    input  logic [7:0]             mem_rd_data,
    output logic                   stall,
    output logic [BLOCK_BYTES-1:0] decOutStall,
    output logic [7:0]             inputData,
    output logic [NUM_LINES-1:0]   decOut1b,
    output logic                   block_write,
    output logic [TAG_W-1:0]       in_tag,
    output logic                   inp_viv,
    output logic                   fill_done,
    output logic                   busy
`ifdef CACHE_REFILL_CRIT_FIRST_EN
    ,
    output logic                   crit_valid
`endif
);

    localparam int unsigned BO_W  = $clog2(BLOCK_BYTES);
    localparam int unsigned LI_W  = $clog2(NUM_LINES);
    localparam int unsigned LI_LSB = BO_W;
    localparam int unsigned TG_LSB = BO_W + LI_W;
    localparam logic [BO_W-1:0] LAST_BEAT = BO_W'(BLOCK_BYTES - 1);

    refill_state_t   state_q;
    logic [TAG_W-1:0] tag_q;
    logic [LI_W-1:0]  line_q;
    logic [BO_W-1:0]  beat_q;
    logic [BO_W-1:0]  idx_q;
    logic [7:0]       data_q;
    logic [BO_W-1:0]  cur_idx;

    logic st_fill;
    logic st_write;
    logic st_commit;
    logic st_done;

    assign st_fill   = (state_q == ST_FILL);
    assign st_write  = (state_q == ST_WRITE);
    assign st_commit = (state_q == ST_COMMIT);
    assign st_done   = (state_q == ST_DONE);

`ifdef CACHE_REFILL_CRIT_FIRST_EN
    logic [BO_W-1:0] start_q;

    // Fetch-order origin: the missing byte offset, captured with the miss
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q <= '0;
        end else if (state_q == ST_IDLE && miss_req) begin
            start_q <= miss_addr[BO_W-1:0];
        end
    end

    // Modulo-block add gives the wrap from byte 31 back to byte 0
    assign cur_idx    = start_q + beat_q;
    assign crit_valid = st_write && (beat_q == '0);
`else
    logic unused_offset;

    // Linear fetch order starting at byte 0; the miss offset is not needed
    assign cur_idx       = beat_q;
    assign unused_offset = ^miss_addr[BO_W-1:0];
`endif

    // Refill sequencer: latch miss, alternate FILL/WRITE per byte, commit, done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            tag_q   <= '0;
            line_q  <= '0;
            beat_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (miss_req) begin
                        tag_q   <= miss_addr[TG_LSB +: TAG_W];
                        line_q  <= miss_addr[LI_LSB +: LI_W];
                        beat_q  <= '0;
                        state_q <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (mem_rd_valid) begin
                        data_q  <= mem_rd_data;
                        idx_q   <= cur_idx;
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // Counter rolls over to zero exactly on the last beat
                    beat_q <= beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_q <= ST_COMMIT;
                    end else begin
                        state_q <= ST_FILL;
                    end
                end
                ST_COMMIT: begin
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // State-decoded outputs; all zero in IDLE so reset clears them asynchronously
    always_comb begin
        mem_rd_req  = st_fill;
        mem_addr    = '0;
        if (st_fill) begin
            mem_addr = {tag_q, line_q, cur_idx};
        end
        stall       = st_fill || st_write || st_commit;
        inputData   = st_write ? data_q : '0;
        block_write = st_commit;
        in_tag      = st_commit ? tag_q : '0;
        inp_viv     = st_commit;
        fill_done   = st_done;
        busy        = (state_q != ST_IDLE);
    end

    onehot_dec #(
        .N(BO_W)
    ) u_byte_dec (
        .en    (st_write),
        .idx   (idx_q),
        .onehot(decOutStall)
    );

    onehot_dec #(
        .N(LI_W)
    ) u_line_dec (
        .en    (st_write || st_commit),
        .idx   (line_q),
        .onehot(decOut1b)
    );

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: stimulus pushes expected fill writes
// and commits; a negedge monitor pops and compares whenever the DUT presents them.
`timescale 1ns/1ps
module tb_cache_refill_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        miss_req = 1'b0;
    logic [31:0] miss_addr = '0;
    logic        mem_rd_req;
    logic [31:0] mem_addr;
    logic        mem_rd_valid = 1'b0;
    logic [7:0]  mem_rd_data = '0;
    logic        stall;
    logic [31:0] decOutStall;
    logic [7:0]  inputData;
    logic [7:0]  decOut1b;
    logic        block_write;
    logic [23:0] in_tag;
    logic        inp_viv;
    logic        fill_done;
    logic        busy;
`ifdef CACHE_REFILL_CRIT_FIRST_EN
    logic        crit_valid;
`endif

    cache_refill_ctrl #(
        .BLOCK_BYTES(32),
        .TAG_W(24),
        .NUM_LINES(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .miss_req    (miss_req),
        .miss_addr   (miss_addr),
        .mem_rd_req  (mem_rd_req),
        .mem_addr    (mem_addr),
        .mem_rd_valid(mem_rd_valid),
        .mem_rd_data (mem_rd_data),
        .stall       (stall),
        .decOutStall (decOutStall),
        .inputData   (inputData),
        .decOut1b    (decOut1b),
        .block_write (block_write),
        .in_tag      (in_tag),
        .inp_viv     (inp_viv),
        .fill_done   (fill_done),
        .busy        (busy)
`ifdef CACHE_REFILL_CRIT_FIRST_EN
        ,
        .crit_valid  (crit_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sel;
        logic [7:0]  data;
        logic [7:0]  line;
        logic        crit;
    } wr_t;

    typedef struct {
        logic [23:0] tag;
        logic [7:0]  line;
    } cm_t;

    wr_t wr_q[$];
    cm_t cm_q[$];

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned cyc = 0;
    int unsigned writes_seen = 0;
    int unsigned bw_count = 0;
    int unsigned done_count = 0;
    int unsigned done_cyc = 0;
    int unsigned gap_max = 0;
    logic        junk_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory model: returns byte = address[7:0] after a 0..gap_max cycle gap
    initial begin : mem_model
        int unsigned wait_n;
        logic        waiting;
        logic [31:0] last_addr;
        wait_n = 0;
        waiting = 1'b0;
        last_addr = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mem_rd_valid = 1'b0;
                wait_n = 0;
                waiting = 1'b0;
            end else if (junk_valid) begin
                mem_rd_valid = 1'b1;
                mem_rd_data = 8'($urandom);
            end else if (mem_rd_req) begin
                if (waiting) chk("mem_addr_stable", 128'(mem_addr), 128'(last_addr));
                if (wait_n == 0) begin
                    mem_rd_valid = 1'b1;
                    mem_rd_data = mem_addr[7:0];
                    waiting = 1'b0;
                    wait_n = (gap_max == 0) ? 0 : $urandom_range(gap_max, 0);
                end else begin
                    mem_rd_valid = 1'b0;
                    wait_n--;
                    waiting = 1'b1;
                    last_addr = mem_addr;
                end
            end else begin
                mem_rd_valid = 1'b0;
                mem_rd_data = '0;
            end
        end
    end

    // Monitor: pops expectations whenever a fill write or commit appears
    initial begin : monitor
        logic prev_stall;
        logic prev_bw;
        logic prev_rst;
        wr_t  w;
        cm_t  c;
        prev_stall = 1'b0;
        prev_bw = 1'b0;
        prev_rst = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (reset && prev_rst) begin
                if (decOutStall != '0) begin
                    writes_seen++;
                    if (wr_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write actual=%0h required=none", decOutStall);
                    end else begin
                        w = wr_q.pop_front();
                        chk("wr_sel", 128'(decOutStall), 128'(w.sel));
                        chk("wr_data", 128'(inputData), 128'(w.data));
                        chk("wr_line", 128'(decOut1b), 128'(w.line));
                        chk("wr_stall", 128'(stall), 128'(1));
`ifdef CACHE_REFILL_CRIT_FIRST_EN
                        chk("crit_valid", 128'(crit_valid), 128'(w.crit));
`endif
                    end
                end
                if (block_write) begin
                    bw_count++;
                    if (cm_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_block_write actual=%0h required=none", in_tag);
                    end else begin
                        c = cm_q.pop_front();
                        chk("commit_tag", 128'(in_tag), 128'(c.tag));
                        chk("commit_viv", 128'(inp_viv), 128'(1));
                        chk("commit_line", 128'(decOut1b), 128'(c.line));
                        chk("commit_stall", 128'(stall), 128'(1));
                    end
                end
                if (fill_done) begin
                    done_count++;
                    done_cyc = cyc;
                    chk("done_stall_low", 128'(stall), 128'(0));
                end
                if (prev_stall && !stall) chk("stall_continuous", 128'(prev_bw), 128'(1));
            end
            prev_stall = stall;
            prev_bw = block_write;
            prev_rst = reset;
        end
    end

    task automatic push_refill(input logic [31:0] addr, input logic crit_order);
        logic [4:0] st;
        logic [4:0] idx;
        wr_t w;
        cm_t c;
        st = crit_order ? addr[4:0] : 5'd0;
        for (int b = 0; b < 32; b++) begin
            idx = st + 5'(b);
            w.sel = 32'h1 << idx;
            w.data = {addr[7:5], idx};
            w.line = 8'h1 << addr[7:5];
            w.crit = (b == 0);
            wr_q.push_back(w);
        end
        c.tag = addr[31:8];
        c.line = 8'h1 << addr[7:5];
        cm_q.push_back(c);
    endtask

    task automatic issue_miss(input logic [31:0] addr, input int unsigned gap, output int unsigned mcyc);
        logic crit_order;
`ifdef CACHE_REFILL_CRIT_FIRST_EN
        crit_order = 1'b1;
`else
        crit_order = 1'b0;
`endif
        push_refill(addr, crit_order);
        gap_max = gap;
        @(negedge clk);
        miss_addr = addr;
        miss_req = 1'b1;
        mcyc = cyc;
        @(negedge clk);
        miss_req = 1'b0;
    endtask

    task automatic wait_done(input int unsigned target, input string name);
        int unsigned n;
        n = 0;
        while (done_count < target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (done_count < target) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=%0d required=%0d", name, done_count, target);
        end
        repeat (2) @(posedge clk);
        chk({name, "_wr_q_empty"}, 128'(wr_q.size()), 128'(0));
        chk({name, "_cm_q_empty"}, 128'(cm_q.size()), 128'(0));
    endtask

    function automatic logic [127:0] all_outputs();
        logic [127:0] v;
        v = 128'({mem_rd_req, mem_addr, stall, decOutStall, inputData, decOut1b,
                  block_write, in_tag, inp_viv, fill_done, busy});
`ifdef CACHE_REFILL_CRIT_FIRST_EN
        v = v | 128'(crit_valid);
`endif
        return v;
    endfunction

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : stimulus
        int unsigned m;
        int unsigned w0;
        int unsigned b0;
        int unsigned n;

        // Reset state
        #1;
        chk("reset_outputs", all_outputs(), 128'(0));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-wait refill, latency and counts
        w0 = writes_seen;
        b0 = bw_count;
        issue_miss(32'h1234_56A7, 0, m);
        wait_done(1, "zero_wait");
        chk("latency", 128'(done_cyc - m + 1), 128'(67));
        chk("zero_wait_writes", 128'(writes_seen - w0), 128'(32));
        chk("zero_wait_bw", 128'(bw_count - b0), 128'(1));

        // Random-gap memory
        w0 = writes_seen;
        issue_miss(32'hCAFE_F0E9, 5, m);
        wait_done(2, "gap");
        chk("gap_writes", 128'(writes_seen - w0), 128'(32));

        // Second miss during FILL is ignored
        b0 = bw_count;
        issue_miss(32'h0BAD_C04C, 1, m);
        repeat (9) @(negedge clk);
        miss_addr = 32'hFFFF_FFFF;
        miss_req = 1'b1;
        @(negedge clk);
        miss_req = 1'b0;
        wait_done(3, "second_miss");
        chk("second_miss_bw", 128'(bw_count - b0), 128'(1));

        // Reset at beat 17
        w0 = writes_seen;
        b0 = bw_count;
        issue_miss(32'h55AA_3360, 0, m);
        n = 0;
        while (writes_seen - w0 < 17 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("reach_beat17", 128'(writes_seen - w0), 128'(17));
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset_outputs", all_outputs(), 128'(0));
        wr_q.delete();
        cm_q.delete();
        repeat (3) @(negedge clk);
        chk("reset_hold_outputs", all_outputs(), 128'(0));
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_no_bw", 128'(bw_count - b0), 128'(0));
        issue_miss(32'h89AB_CDEF, 2, m);
        wait_done(4, "after_reset");

        // Offset 0x1D: wraps 31->0 when critical-first is enabled
        issue_miss(32'hABCD_EF1D, 0, m);
        wait_done(5, "crit");

        // mem_rd_valid pulses while idle
        w0 = writes_seen;
        junk_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #2;
            chk("idle_stall", 128'(stall), 128'(0));
            chk("idle_busy", 128'(busy), 128'(0));
            chk("idle_byte_sel", 128'(decOutStall), 128'(0));
        end
        junk_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_no_writes", 128'(writes_seen - w0), 128'(0));
        chk("total_done", 128'(done_count), 128'(5));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
